// File: rtl/mont_word_sequencer_pkg.sv
// Shared RSA sequencing types: FSM state encoding and datapath phase codes.
package mont_word_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    CARRY = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_MUL   = 2'd1;
  localparam logic [1:0] PH_CARRY = 2'd2;
  localparam logic [1:0] PH_SUB   = 2'd3;

  // Phase code presented to the datapath for a given sequencer state.
  function automatic logic [1:0] phase_of(input logic [2:0] st);
    logic [1:0] ph;
    ph = PH_IDLE;
    case (st)
      MUL:     ph = PH_MUL;
      CARRY:   ph = PH_CARRY;
      SUB:     ph = PH_SUB;
      default: ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/mont_word_sequencer_if.sv
// Bundle of the start/busy/done handshake (exponentiation controller side)
// and the valid/ready step handshake plus word indices (datapath side).
// master = the sequencer, slave = its environment.
interface mont_word_sequencer_if #(
  parameter int CNT_W = 11
);
  logic             start;
  logic [CNT_W-1:0] t_sub_1;
  logic             busy;
  logic             done;
  logic             step_valid;
  logic             step_ready;
  logic [1:0]       phase;
  logic [CNT_W-1:0] idx_i;
  logic [CNT_W-1:0] idx_j;
  logic             first_j;
  logic             last_j;
  logic             last_i;
  logic             carry_en;

  modport master (
    input  start, t_sub_1, step_ready,
    output busy, done, step_valid, phase, idx_i, idx_j,
           first_j, last_j, last_i, carry_en
  );

  modport slave (
    output start, t_sub_1, step_ready,
    input  busy, done, step_valid, phase, idx_i, idx_j,
           first_j, last_j, last_i, carry_en
  );
endinterface

// File: rtl/mont_word_sequencer_counter.sv
// Wrap-around word counter: counts 0..t_sub_1 and wraps to 0 after t_sub_1.
// The wrap is an equality compare, so t_sub_1 = all-ones never overflows.
module counter_to_t_sub_1 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         inc,
  input  logic [W-1:0] t_sub_1,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: advance or wrap on an enabled increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (ce && inc) begin
      if (cnt_q == t_sub_1) cnt_d = '0;
      else                  cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mont_word_sequencer.sv
// Word-serial Montgomery multiplier control: outer loop i, inner loop j,
// one carry cycle per outer iteration, then a conditional-subtraction pass.
//
// state | meaning
// IDLE  | waiting for start
// MUL   | inner-loop multiply steps, j advances on step handshake
// CARRY | one-cycle carry propagation, i advances
// SUB   | final subtraction pass, j advances on step handshake
// DONE  | one-cycle completion flag
module mont_word_sequencer
  import mont_word_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 1025,
  localparam int CNT_W = $clog2(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  mont_word_sequencer_if.master        bus
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_MUL   = MUL;
  localparam logic [2:0] S_CARRY = CARRY;
  localparam logic [2:0] S_SUB   = SUB;
  localparam logic [2:0] S_DONE  = DONE;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] t_reg_q, t_reg_d;
  logic [CNT_W-1:0] cnt_i, cnt_j;
  logic             start_acc;
  logic             step_valid;
  logic             j_inc;
  logic             i_inc;
  logic             j_last;
  logic             i_last;
  logic             cnt_rst;

  assign start_acc  = ce && (state_q == S_IDLE) && bus.start;
  assign step_valid = (state_q == S_MUL) || (state_q == S_SUB);
  assign j_inc      = step_valid && bus.step_ready;
  assign i_inc      = (state_q == S_CARRY);
  assign j_last     = (cnt_j == t_reg_q);
  assign i_last     = (cnt_i == t_reg_q);
  // Starting a run clears both counters so every run begins at word 0.
  assign cnt_rst    = rst || start_acc;

  counter_to_t_sub_1 #(.W(CNT_W)) u_cnt_i (
    .clk     (clk),
    .rst     (cnt_rst),
    .ce      (ce),
    .inc     (i_inc),
    .t_sub_1 (t_reg_q),
    .cnt     (cnt_i)
  );

  counter_to_t_sub_1 #(.W(CNT_W)) u_cnt_j (
    .clk     (clk),
    .rst     (cnt_rst),
    .ce      (ce),
    .inc     (j_inc),
    .t_sub_1 (t_reg_q),
    .cnt     (cnt_j)
  );

  // Next state and word-count capture; everything holds while ce is low.
  always_comb begin
    state_d = state_q;
    t_reg_d = t_reg_q;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            t_reg_d = bus.t_sub_1;
            state_d = S_MUL;
          end
        end
        S_MUL: begin
          if (bus.step_ready && j_last) state_d = S_CARRY;
        end
        S_CARRY: begin
          if (i_last) state_d = S_SUB;
          else        state_d = S_MUL;
        end
        S_SUB: begin
          if (bus.step_ready && j_last) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and word-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_reg_q <= '0;
    end else begin
      state_q <= state_d;
      t_reg_q <= t_reg_d;
    end
  end

  assign bus.busy       = (state_q == S_MUL) || (state_q == S_CARRY) || (state_q == S_SUB);
  assign bus.done       = (state_q == S_DONE);
  assign bus.step_valid = step_valid;
  assign bus.phase      = phase_of(state_q);
  assign bus.carry_en   = (state_q == S_CARRY);
  assign bus.idx_i      = cnt_i;
  assign bus.idx_j      = cnt_j;
  assign bus.first_j    = (cnt_j == '0);
  assign bus.last_j     = j_last;
  assign bus.last_i     = i_last;

endmodule
